// File: rtl/neuron_layer_pkg.sv
// Shared definitions for the neuron layer: FSM state encoding and activation selectors.
package neuron_layer_pkg;

    typedef enum logic [1:0] {
        StIdle  = 2'd0,
        StAccum = 2'd1,
        StAct   = 2'd2
    } state_e;

    localparam int unsigned ACT_IDENT = 0;
    localparam int unsigned ACT_RELU  = 1;

endpackage

// File: rtl/neuron_layer_if.sv
// Handshake/data bundle between the feature source and the neuron layer.
interface neuron_layer_if #(
    parameter int unsigned IN_W  = 8,
    parameter int unsigned W_W   = 8,
    parameter int unsigned ACC_W = 18,
    parameter int unsigned P     = 2
);
    logic                 start;
    logic [P*ACC_W-1:0]   bias;
    logic [IN_W-1:0]      in;
    logic [P*W_W-1:0]     weight;
    logic                 in_valid;
    logic                 in_ready;
    logic [P*ACC_W-1:0]   out;
    logic                 ready;
    logic [P-1:0]         sat;

    modport master (
        output start, bias, in, weight, in_valid,
        input  in_ready, out, ready, sat
    );

    modport slave (
        input  start, bias, in, weight, in_valid,
        output in_ready, out, ready, sat
    );
endinterface

// File: rtl/neuron_layer_mac_lane.sv
// One neuron lane: multiply the shared sample by the lane weight, accumulate with
// saturation, and apply the activation when the layer fires.
module neuron_layer_mac_lane
    import neuron_layer_pkg::*;
#(
    parameter int unsigned IN_W  = 8,
    parameter int unsigned W_W   = 8,
    parameter int unsigned ACC_W = 18,
    parameter int unsigned ACT   = ACT_RELU
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic             beat,
    input  logic             fire,
    input  logic [ACC_W-1:0] bias,
    input  logic [IN_W-1:0]  sample,
    input  logic [W_W-1:0]   weight,
    output logic [ACC_W-1:0] out,
    output logic             sat
);

    localparam logic [ACC_W-1:0] MaxVal = {1'b0, {(ACC_W-1){1'b1}}};
    localparam logic [ACC_W-1:0] MinVal = {1'b1, {(ACC_W-1){1'b0}}};

    logic signed [IN_W+W_W-1:0] prod;
    logic signed [ACC_W-1:0]    prod_ext;
    logic [ACC_W-1:0]           acc_q;
    logic [ACC_W-1:0]           acc_d;
    logic                       ovf;
    logic                       sat_run_q;
    logic [ACC_W-1:0]           out_q;
    logic                       sat_q;
    logic [ACC_W-1:0]           act_val;

    // Add at ACC_W+1 bits; a mismatch of the top two bits means the result left the range.
    function automatic logic [ACC_W:0] sat_add(input logic [ACC_W-1:0] a,
                                                input logic [ACC_W-1:0] b);
        logic [ACC_W:0] s;
        logic [ACC_W:0] r;
        s = {a[ACC_W-1], a} + {b[ACC_W-1], b};
        if (s[ACC_W] != s[ACC_W-1]) begin
            r = {1'b1, s[ACC_W] ? MinVal : MaxVal};
        end else begin
            r = {1'b0, s[ACC_W-1:0]};
        end
        return r;
    endfunction

    // Full-precision product, sign-extended into the accumulator width.
    always_comb begin
        prod     = $signed(sample) * $signed(weight);
        prod_ext = ACC_W'(prod);
        {ovf, acc_d} = sat_add(acc_q, prod_ext);
        if (ACT == ACT_RELU && acc_q[ACC_W-1]) begin
            act_val = '0;
        end else begin
            act_val = acc_q;
        end
    end

    // Accumulator, sticky run flag and the published result/flag registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            acc_q     <= '0;
            sat_run_q <= 1'b0;
            out_q     <= '0;
            sat_q     <= 1'b0;
        end else begin
            if (load) begin
                acc_q     <= bias;
                sat_run_q <= 1'b0;
            end else if (beat) begin
                acc_q <= acc_d;
                if (ovf) begin
                    sat_run_q <= 1'b1;
                end
            end
            // The visible flag only changes on fire so it survives the next start.
            if (fire) begin
                out_q <= act_val;
                sat_q <= sat_run_q;
            end
        end
    end

    assign out = out_q;
    assign sat = sat_q;

endmodule

// File: rtl/neuron_layer.sv
// P parallel serial neurons sharing one input stream. Holds the control FSM and
// beat counter; the arithmetic lives in one mac lane per neuron.
module neuron_layer
    import neuron_layer_pkg::*;
#(
    parameter int unsigned IN_W  = 8,
    parameter int unsigned W_W   = 8,
    parameter int unsigned ACC_W = 18,
    parameter int unsigned M     = 4,
    parameter int unsigned P     = 2,
    parameter int unsigned ACT   = ACT_RELU
) (
    input  logic          clk,
    input  logic          rst,
    neuron_layer_if.slave bus
);

    localparam int unsigned CntW = (M > 1) ? $clog2(M) : 1;

    state_e             state_q;
    logic [CntW-1:0]    cnt_q;
    logic               in_ready_q;
    logic               ready_q;
    logic               load;
    logic               beat;
    logic               fire;
    logic               last;
    logic [P*ACC_W-1:0] out_w;
    logic [P-1:0]       sat_w;

    // Lane strobes decoded from the current state.
    always_comb begin
        load = (state_q == StIdle) && bus.start;
        beat = bus.in_valid && in_ready_q;
        fire = (state_q == StAct);
        last = (cnt_q == CntW'(M - 1));
    end

    // Control FSM with registered handshake outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= StIdle;
            cnt_q      <= '0;
            in_ready_q <= 1'b0;
            ready_q    <= 1'b0;
        end else begin
            ready_q <= 1'b0;
            unique case (state_q)
                StIdle: begin
                    if (bus.start) begin
                        state_q    <= StAccum;
                        cnt_q      <= '0;
                        in_ready_q <= 1'b1;
                    end
                end
                StAccum: begin
                    if (beat) begin
                        if (last) begin
                            state_q    <= StAct;
                            cnt_q      <= '0;
                            in_ready_q <= 1'b0;
                        end else begin
                            cnt_q <= cnt_q + 1'b1;
                        end
                    end
                end
                StAct: begin
                    ready_q <= 1'b1;
                    state_q <= StIdle;
                end
                default: begin
                    state_q    <= StIdle;
                    in_ready_q <= 1'b0;
                end
            endcase
        end
    end

    for (genvar k = 0; k < P; k++) begin : g_lane
        neuron_layer_mac_lane #(
            .IN_W  (IN_W),
            .W_W   (W_W),
            .ACC_W (ACC_W),
            .ACT   (ACT)
        ) u_lane (
            .clk    (clk),
            .rst    (rst),
            .load   (load),
            .beat   (beat),
            .fire   (fire),
            .bias   (bus.bias[k*ACC_W +: ACC_W]),
            .sample (bus.in),
            .weight (bus.weight[k*W_W +: W_W]),
            .out    (out_w[k*ACC_W +: ACC_W]),
            .sat    (sat_w[k])
        );
    end

    assign bus.in_ready = in_ready_q;
    assign bus.ready    = ready_q;
    assign bus.out      = out_w;
    assign bus.sat      = sat_w;

endmodule
